// File: rtl/i2c_pkg.sv
// Shared types and constants for the emulated I2C temperature sensor.
package i2c_pkg;

  // Responder protocol states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_TX,
    ST_M_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic [6:0] TEMP_SENSOR_ADDR = 7'h4B;
  localparam logic       RD_BIT           = 1'b1;

  // Two-byte sensor word: sign bit, integer degrees, sixteenths, three zero pad bits.
  function automatic logic [15:0] temp_word(input logic [7:0] temp_c,
                                            input logic [3:0] temp_frac);
    return {1'b0, temp_c, temp_frac, 3'b000};
  endfunction

endpackage

// File: rtl/i2c_temp_responder_if.sv
// Sensor-side signal bundle of the temperature responder: SCL from the master,
// the temperature inputs and the status outputs.
interface i2c_temp_responder_if;
  logic       SCL;
  logic [7:0] temp_c;
  logic [3:0] temp_frac;
  logic       sda_oe;
  logic       busy;
  logic       xfer_done;

  modport master (
    output SCL, temp_c, temp_frac,
    input  sda_oe, busy, xfer_done
  );

  modport slave (
    input  SCL, temp_c, temp_frac,
    output sda_oe, busy, xfer_done
  );
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL and SDA into the 200 kHz domain and derives edge and
// bus-condition strobes from the synchronized levels.
module i2c_line_sync (
  input  logic clk_200kHz,
  input  logic reset,
  input  logic scl_pin,
  input  logic sda_pin,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // [0],[1] form the synchronizer; [2] holds the previous synchronized level.
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // Shift both pins through their three-flop pipelines.
  always_ff @(posedge clk_200kHz or posedge reset) begin
    if (reset) begin
      // NOTE: preset to the idle-bus level (1) so leaving reset never fakes an edge or START.
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value of the one before it.
      scl_q <= {scl_q[1:0], scl_pin};
      sda_q <= {sda_q[1:0], sda_pin};
    end
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  // Bus conditions require SCL to be high both before and after the SDA edge.
  assign start_det =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_det  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C read-only target that emulates the temperature sensor: ACKs a read at
// ADDR and streams the snapshotted temperature word MSB byte first, wrapping
// while the master keeps ACKing.
module i2c_temp_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = TEMP_SENSOR_ADDR
) (
  input  logic                 clk_200kHz,
  input  logic                 reset,
  i2c_temp_responder_if.slave  bus,
  inout  wire                  SDA
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync u_line_sync (
    .clk_200kHz (clk_200kHz),
    .reset      (reset),
    .scl_pin    (bus.SCL),
    .sda_pin    (SDA),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .sda_s      (sda_s)
  );

  i2c_state_e  state;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_cnt;
  logic        byte_sel;   // 0 = MSB byte, 1 = LSB byte
  logic        phase;      // second half of ACK_A / ACK seen in M_ACK
  logic [15:0] data_word;
  logic        sda_oe_r;
  logic        busy_r;
  logic        xfer_done_r;

  logic [7:0] addr_byte;
  logic [7:0] tx_byte;
  logic       start_ok;
  logic       stop_ok;

  assign addr_byte = {shift_reg[6:0], sda_s};
  assign tx_byte   = byte_sel ? data_word[7:0] : data_word[15:8];
  // Our own pull-down must never be mistaken for a master-generated condition.
  assign start_ok  = start_det & ~sda_oe_r;
  assign stop_ok   = stop_det  & ~sda_oe_r;

  // Protocol FSM with registered bus drive and status outputs.
  always_ff @(posedge clk_200kHz or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      byte_sel    <= 1'b0;
      phase       <= 1'b0;
      data_word   <= '0;
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
      xfer_done_r <= 1'b0;
    end else begin
      // NOTE: default-low here turns any single assignment below into a one-cycle pulse.
      xfer_done_r <= 1'b0;
      if (start_ok) begin
        state    <= ST_ADDR;
        bit_cnt  <= '0;
        phase    <= 1'b0;
        sda_oe_r <= 1'b0;
        busy_r   <= 1'b0;
      end else if (stop_ok) begin
        state    <= ST_IDLE;
        bit_cnt  <= '0;
        phase    <= 1'b0;
        sda_oe_r <= 1'b0;
        busy_r   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            sda_oe_r <= 1'b0;
          end

          ST_ADDR: begin
            if (scl_rise) begin
              shift_reg <= addr_byte;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (addr_byte[7:1] == ADDR && addr_byte[0] == RD_BIT) begin
                  state     <= ST_ACK_A;
                  busy_r    <= 1'b1;
                  phase     <= 1'b0;
                  data_word <= temp_word(bus.temp_c, bus.temp_frac);
                end else begin
                  state <= ST_IGNORE;
                end
              end
            end
          end

          ST_ACK_A: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe_r <= 1'b1;
                phase    <= 1'b1;
              end else begin
                phase     <= 1'b0;
                byte_sel  <= 1'b0;
                bit_cnt   <= 3'd7;
                sda_oe_r  <= ~data_word[15];
                shift_reg <= {data_word[14:8], 1'b0};
                state     <= ST_TX;
              end
            end
          end

          ST_TX: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe_r <= 1'b0;
                phase    <= 1'b0;
                state    <= ST_M_ACK;
              end else begin
                sda_oe_r  <= ~shift_reg[7];
                shift_reg <= {shift_reg[6:0], 1'b0};
                bit_cnt   <= bit_cnt - 3'd1;
              end
            end
          end

          ST_M_ACK: begin
            if (scl_rise && !phase) begin
              if (sda_s) begin
                xfer_done_r <= 1'b1;
                busy_r      <= 1'b0;
                state       <= ST_IDLE;
              end else begin
                phase    <= 1'b1;
                byte_sel <= ~byte_sel;
              end
            end else if (scl_fall && phase) begin
              phase     <= 1'b0;
              bit_cnt   <= 3'd7;
              sda_oe_r  <= ~tx_byte[7];
              shift_reg <= {tx_byte[6:0], 1'b0};
              state     <= ST_TX;
            end
          end

          ST_IGNORE: begin
            sda_oe_r <= 1'b0;
          end

          default: begin
            state    <= ST_IDLE;
            sda_oe_r <= 1'b0;
            busy_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sda_oe    = sda_oe_r;
  assign bus.busy      = busy_r;
  assign bus.xfer_done = xfer_done_r;

  // Open-drain pad: only ever pull low, the bus pull-up supplies the 1.
  assign SDA = sda_oe_r ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_temp_responder.sv
// Bench for the I2C temperature responder: bit-banged 10 kHz master, table of
// read transactions, randomized reads against an arithmetic model, and
// hand-written wrap, repeated-START, snapshot and reset sequences.
module tb_i2c_temp_responder;

  logic clk;
  logic reset;
  logic m_sda_low;
  wire  SDA;

  i2c_temp_responder_if bus_if ();

  pullup (SDA);
  assign SDA = m_sda_low ? 1'b0 : 1'bz;

  i2c_temp_responder dut (
    .clk_200kHz (clk),
    .reset      (reset),
    .bus        (bus_if),
    .SDA        (SDA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Bus monitors (monotonic counters, read as deltas by the test).
  int   move_viol = 0;
  int   xfer_cycles = 0;
  int   busy_cycles = 0;
  int   oe_cycles = 0;
  logic scl_prev = 1'b1;
  logic oe_prev = 1'b0;
  logic rst_prev = 1'b1;

  always @(posedge clk) begin
    if (!reset && !rst_prev && bus_if.SCL && scl_prev && bus_if.sda_oe !== oe_prev)
      move_viol <= move_viol + 1;
    if (bus_if.xfer_done === 1'b1) xfer_cycles <= xfer_cycles + 1;
    if (bus_if.busy === 1'b1)      busy_cycles <= busy_cycles + 1;
    if (bus_if.sda_oe === 1'b1)    oe_cycles   <= oe_cycles + 1;
    scl_prev <= bus_if.SCL;
    oe_prev  <= bus_if.sda_oe;
    rst_prev <= reset;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] tc;
    logic [3:0] tf;
    logic [7:0] addr;
    logic       exp_ack;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  // Reference model: the sensor word is temperature in 1/128 degC units.
  function automatic vec_t mk(input int tc, input int tf, input int addr);
    vec_t v;
    int   word;
    word      = (tc * 16 + tf) * 8;
    v.tc      = tc[7:0];
    v.tf      = tf[3:0];
    v.addr    = addr[7:0];
    v.exp_ack = ((addr / 2) == 75) && ((addr % 2) == 1);
    v.exp_msb = 8'((word / 256) % 256);
    v.exp_lsb = 8'(word % 256);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (bus_if.SCL == 1'b0) begin
      wait_cyc(3);
      m_sda_low = 1'b0;
      wait_cyc(5);
      bus_if.SCL = 1'b1;
      wait_cyc(5);
    end
    m_sda_low = 1'b1;
    wait_cyc(5);
    bus_if.SCL = 1'b0;
  endtask

  task automatic bus_stop();
    wait_cyc(3);
    m_sda_low = 1'b1;
    wait_cyc(4);
    bus_if.SCL = 1'b1;
    wait_cyc(5);
    m_sda_low = 1'b0;
    wait_cyc(10);
  endtask

  task automatic write_bit(input logic b);
    wait_cyc(3);
    m_sda_low = ~b;
    wait_cyc(7);
    bus_if.SCL = 1'b1;
    wait_cyc(10);
    bus_if.SCL = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_cyc(3);
    m_sda_low = 1'b0;
    wait_cyc(7);
    bus_if.SCL = 1'b1;
    wait_cyc(5);
    b = SDA;
    wait_cyc(5);
    bus_if.SCL = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
  endtask

  // Reads 8 bits, then answers with ACK (ack=1) or NACK (ack=0).
  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~ack);
  endtask

  // One complete read transaction checked against the model record.
  task automatic run_read(input vec_t v, input string tag);
    logic [7:0] d;
    logic       ack_slot;
    int         x0, b0, o0;
    bus_if.temp_c    = v.tc;
    bus_if.temp_frac = v.tf;
    x0 = xfer_cycles;
    b0 = busy_cycles;
    o0 = oe_cycles;
    bus_start();
    write_byte(v.addr);
    read_bit(ack_slot);
    check({tag, "_ack_slot"}, 32'(ack_slot), 32'(!v.exp_ack));
    if (v.exp_ack) begin
      check({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
      read_byte(d, 1'b1);
      check({tag, "_msb"}, 32'(d), 32'(v.exp_msb));
      read_byte(d, 1'b0);
      check({tag, "_lsb"}, 32'(d), 32'(v.exp_lsb));
      wait_cyc(4);
      check({tag, "_xfer_cycles"}, 32'(xfer_cycles - x0), 32'd1);
    end else begin
      read_byte(d, 1'b0);
      check({tag, "_ign_data"}, 32'(d), 32'hFF);
      check({tag, "_ign_oe"}, 32'(oe_cycles - o0), 32'd0);
      check({tag, "_ign_busy"}, 32'(busy_cycles - b0), 32'd0);
      check({tag, "_ign_xfer"}, 32'(xfer_cycles - x0), 32'd0);
    end
    bus_stop();
    check({tag, "_busy_end"}, 32'(bus_if.busy), 32'd0);
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    logic [7:0] d;
    logic       b;
    int         x0;

    reset            = 1'b1;
    m_sda_low        = 1'b0;
    bus_if.SCL       = 1'b1;
    bus_if.temp_c    = 8'd0;
    bus_if.temp_frac = 4'd0;

    vecs[0] = mk(25,  0,  8'h97);
    vecs[1] = mk(255, 15, 8'h97);
    vecs[2] = mk(0,   0,  8'h97);
    vecs[3] = mk(128, 8,  8'h97);
    vecs[4] = mk(100, 3,  8'h97);
    vecs[5] = mk(25,  0,  8'h96);
    vecs[6] = mk(25,  0,  8'h91);
    vecs[7] = mk(25,  0,  8'h17);

    // Reset state.
    wait_cyc(4);
    check("rst_sda_oe", 32'(bus_if.sda_oe), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_xfer_done", 32'(bus_if.xfer_done), 32'd0);
    check("rst_sda_line", 32'(SDA), 32'd1);
    reset = 1'b0;
    wait_cyc(10);

    // Table-driven transactions.
    for (int i = 0; i < 8; i++) run_read(vecs[i], $sformatf("vec%0d", i));

    // Randomized reads against the model.
    for (int i = 0; i < 6; i++) begin
      rv = mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : 32'h97);
      run_read(rv, $sformatf("rnd%0d", i));
    end

    // Snapshot: inputs change after the address ACK.
    rv = mk(255, 15, 8'h97);
    bus_if.temp_c    = rv.tc;
    bus_if.temp_frac = rv.tf;
    bus_start();
    write_byte(8'h97);
    read_bit(b);
    check("snap_ack", 32'(b), 32'd0);
    bus_if.temp_c    = 8'd0;
    bus_if.temp_frac = 4'd0;
    read_byte(d, 1'b1);
    check("snap_msb", 32'(d), 32'(rv.exp_msb));
    read_byte(d, 1'b0);
    check("snap_lsb", 32'(d), 32'(rv.exp_lsb));
    bus_stop();

    // Wrap: master ACKs the LSB byte and gets the MSB byte again.
    rv = mk(25, 0, 8'h97);
    bus_if.temp_c    = rv.tc;
    bus_if.temp_frac = rv.tf;
    x0 = xfer_cycles;
    bus_start();
    write_byte(8'h97);
    read_bit(b);
    check("wrap_ack", 32'(b), 32'd0);
    read_byte(d, 1'b1);
    check("wrap_msb", 32'(d), 32'(rv.exp_msb));
    read_byte(d, 1'b1);
    check("wrap_lsb", 32'(d), 32'(rv.exp_lsb));
    check("wrap_no_done_yet", 32'(xfer_cycles - x0), 32'd0);
    read_byte(d, 1'b0);
    check("wrap_msb_again", 32'(d), 32'(rv.exp_msb));
    wait_cyc(4);
    check("wrap_done", 32'(xfer_cycles - x0), 32'd1);
    check("wrap_idle_busy", 32'(bus_if.busy), 32'd0);
    bus_stop();

    // Repeated START after the MSB byte (LSB bit7 is 1, so SDA is released).
    bus_start();
    write_byte(8'h97);
    read_bit(b);
    check("rs_ack1", 32'(b), 32'd0);
    read_byte(d, 1'b1);
    check("rs_msb1", 32'(d), 32'(rv.exp_msb));
    bus_start();
    write_byte(8'h97);
    read_bit(b);
    check("rs_ack2", 32'(b), 32'd0);
    read_byte(d, 1'b1);
    check("rs_msb2", 32'(d), 32'(rv.exp_msb));
    read_byte(d, 1'b0);
    check("rs_lsb2", 32'(d), 32'(rv.exp_lsb));
    bus_stop();

    // Reset while the responder is driving a 0 data bit.
    bus_start();
    write_byte(8'h97);
    read_bit(b);
    check("rstmid_ack", 32'(b), 32'd0);
    wait_cyc(8);
    check("rstmid_pre_oe", 32'(bus_if.sda_oe), 32'd1);
    check("rstmid_pre_sda", 32'(SDA), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("rstmid_sda", 32'(SDA), 32'd1);
    check("rstmid_oe", 32'(bus_if.sda_oe), 32'd0);
    check("rstmid_busy", 32'(bus_if.busy), 32'd0);
    check("rstmid_done", 32'(bus_if.xfer_done), 32'd0);
    wait_cyc(3);
    reset = 1'b0;
    bus_stop();
    run_read(mk(25, 0, 8'h97), "post_rst");

    check("sda_stable_while_scl_high", 32'(move_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_temp_responder.md
# i2c_temp_responder

I2C target that emulates the on-board temperature sensor on the 200 kHz system clock. It answers a read at 7-bit address 0x4B (0x97 on the wire with the read bit set) and returns a two-byte temperature word built from internal inputs. It sits on the same SCL/SDA pair as the 10 kHz temperature-reading master and serves as its simulation and loopback partner, so the master can be exercised without the physical sensor.

## Interface
- `ADDR`, default 7'h4B: 7-bit target address.
- `clk_200kHz`  in  1  system clock; SCL is oversampled against it.
- `reset`  in  1  asynchronous, active-high.
- `SCL`  in  1  I2C clock driven by the master (10 kHz nominal).
- `SDA`  inout  1  open-drain: driven to 0 when `sda_oe`=1, otherwise 1'bz.
- `temp_c`  in  8  integer temperature in °C, unsigned.
- `temp_frac`  in  4  fractional temperature in 1/16 °C.
- `sda_oe`  out  1  registered; 1 = responder pulls SDA low.
- `busy`  out  1  high from an address match until the transaction ends.
- `xfer_done`  out  1  one-cycle pulse when the master NACKs the LSB byte.

## Operation
- Line conditioning: SCL and SDA each pass through a 2-flop synchronizer, then a third flop for edge detection.
- START = synchronized SDA falls while synchronized SCL is high. STOP = synchronized SDA rises while synchronized SCL is high.
- START in any state, including mid-byte or a repeated START, goes to ADDR and clears the bit counter.
- STOP in any state goes to IDLE.
- Returned data word = {1'b0, temp_c, temp_frac, 3'b000}; the MSB byte is sent first, MSB-first within each byte.
  - The word is snapshotted on the cycle the address matches. Later changes to `temp_c` or `temp_frac` do not affect the transfer in progress.
- States:
  - IDLE: `sda_oe`=0; wait for START.
  - ADDR: shift the SDA value in on each SCL rise. After 8 bits: if bits[7:1]==`ADDR` and bit0==1, go to ACK_A. Otherwise go to IGNORE.
  - ACK_A: on SCL fall, set `sda_oe`=1. On the next SCL fall, load MSB bit7 and go to TX.
  - TX: on each SCL fall, `sda_oe` = ~current bit. After the 8th bit's SCL fall, set `sda_oe`=0 and go to M_ACK.
  - M_ACK: sample SDA on SCL rise.
    - 0 (ACK) after the MSB byte: go to TX with the LSB byte, first bit placed on the next SCL fall.
    - 0 after the LSB byte: wrap back to the MSB byte.
    - 1 (NACK): pulse `xfer_done` and go to IDLE.
  - IGNORE: `sda_oe`=0; wait for START or STOP. Covers a write request or an address mismatch.
- `busy` is 1 in ACK_A, TX and M_ACK; 0 otherwise.
- Start/stop detection is suppressed while `sda_oe`=1. The responder's own drive is never read back as a bus condition.

## Timing
- Reset values: `sda_oe`=0, `busy`=0, `xfer_done`=0, state IDLE, counters 0.
- Reset is asynchronous and releases SDA immediately, including mid-byte.
- A pin edge is detected 3 clk cycles after it changes on the pin.
- `sda_oe` updates on the cycle after the detected SCL fall, about 4 cycles after the pin edge. This is well inside the 10-cycle SCL-low phase.
- `sda_oe` only changes after a detected SCL fall, so the responder never moves SDA while SCL is high.
- `xfer_done` is asserted exactly 1 cycle, on the cycle after the NACK is sampled.
- If START and STOP are detected in the same cycle, which is impossible on a legal bus, START wins.

## Structure
- Package `i2c_pkg` holds:
  - the state enum (IDLE, ADDR, ACK_A, TX, M_ACK, IGNORE);
  - `TEMP_SENSOR_ADDR` = 7'h4B;
  - `RD_BIT` = 1'b1.
- Sub-module `i2c_line_sync`, instantiated once: synchronizes both lines and emits `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`.
- Top level: FSM, 8-bit shift register, 3-bit bit counter, byte select, 16-bit data snapshot, open-drain assign.

## Test plan
- Master reads at 0x97 with `temp_c`=25 and `temp_frac`=0 → ACK on the 9th clock, bytes 0x0C and 0x80, master decodes 8'd25, `xfer_done` pulses once.
- `temp_c`=0xFF, `temp_frac`=4'hF → bytes 0x7F and 0xF8. Changing `temp_c` after the address ACK does not alter the bytes being sent.
- Address 0x96 (write) or 0x91 (read at 0x48) → `sda_oe` stays 0 through the whole transfer, `busy`=0, SDA reads 1 in the 9th-clock ACK slot.
- Master ACKs the LSB byte → the next 8 bits are 0x0C again (wrap to MSB); the following NACK leads to IDLE.
- Repeated START after the MSB byte, then a new 0x97 read → the responder re-ACKs and restarts from the MSB byte.
- `reset` pulse while driving a 0 data bit → SDA reads 1 within the same cycle, all outputs are 0, and a following full read completes normally.
